// File: rtl/aes_top_pack.sv
// Shared constants and types for the AES-to-Ethernet transmit path.
package aes_top_pack;

    localparam int ADDRESS_SIZE      = 32;
    localparam int REG_SIZE          = 32;
    localparam int AES_DATA_WIDTH    = 128;
    localparam int MAC_STREAM_WIDTH  = 32;
    localparam int MAC_HEADER_WIDTH  = 128;
    localparam int WORD_COUNTER_SIZE = 16;

    // Base byte address of the MAC address register block on Avalon-MM.
    localparam logic [ADDRESS_SIZE-1:0] PERIPHERAL_ADDR = 32'h0000_0400;

    // EtherType carried in the last header word (IPv4).
    localparam logic [15:0] ETH_TYPE = 16'h0800;

    // Register offsets relative to PERIPHERAL_ADDR.
    localparam logic [ADDRESS_SIZE-1:0] SOURCE_MAC_ADDR_1 = 32'h00;
    localparam logic [ADDRESS_SIZE-1:0] SOURCE_MAC_ADDR_2 = 32'h04;
    localparam logic [ADDRESS_SIZE-1:0] DEST_MAC_ADDR_1   = 32'h08;
    localparam logic [ADDRESS_SIZE-1:0] DEST_MAC_ADDR_2   = 32'h0c;
    localparam logic [ADDRESS_SIZE-1:0] FRAME_CNT_ADDR    = 32'h10;

    localparam int WORDS_PER_BLOCK = AES_DATA_WIDTH / MAC_STREAM_WIDTH;
    localparam int HDR_WORDS       = MAC_HEADER_WIDTH / MAC_STREAM_WIDTH;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HDR     = 2'd1,
        PAYLOAD = 2'd2,
        FETCH   = 2'd3
    } tx_state_e;

endpackage

// File: rtl/aes_mac_regs.sv
// Avalon-MM register file holding the source/destination MAC addresses,
// plus shadow copies that are frozen at each frame start so a frame is
// always built from one consistent pair of addresses.
module aes_mac_regs
    import aes_top_pack::*;
#(
    parameter logic [47:0] DEF_SRC_MAC = 48'h0,
    parameter logic [47:0] DEF_DST_MAC = 48'hFFFF_FFFF_FFFF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [ADDRESS_SIZE-1:0]      avs_address,
    input  logic                         avs_write,
    input  logic [REG_SIZE-1:0]          avs_writedata,
    input  logic                         avs_read,
    output logic [REG_SIZE-1:0]          avs_readdata,
    input  logic [WORD_COUNTER_SIZE-1:0] i_frame_cnt,
    input  logic                         i_start,
    output logic [47:0]                  o_sh_src,
    output logic [47:0]                  o_sh_dst
);

    logic [47:0]             r_src;
    logic [47:0]             r_dst;
    logic [47:0]             r_sh_src;
    logic [47:0]             r_sh_dst;
    logic [REG_SIZE-1:0]     r_readdata;
    logic [ADDRESS_SIZE-1:0] w_offset;
    logic [REG_SIZE-1:0]     w_rd_mux;

    assign w_offset     = avs_address - PERIPHERAL_ADDR;
    assign avs_readdata = r_readdata;
    assign o_sh_src     = r_sh_src;
    assign o_sh_dst     = r_sh_dst;

    // Read mux; unmapped offsets read as zero.
    always_comb begin
        w_rd_mux = '0;
        case (w_offset)
            SOURCE_MAC_ADDR_1: w_rd_mux = {16'h0, r_src[47:32]};
            SOURCE_MAC_ADDR_2: w_rd_mux = r_src[31:0];
            DEST_MAC_ADDR_1:   w_rd_mux = {16'h0, r_dst[47:32]};
            DEST_MAC_ADDR_2:   w_rd_mux = r_dst[31:0];
            FRAME_CNT_ADDR:    w_rd_mux = {{(REG_SIZE-WORD_COUNTER_SIZE){1'b0}}, i_frame_cnt};
            default:           w_rd_mux = '0;
        endcase
    end

    // Register writes, registered read data, and shadow capture at frame start.
    // Shadows sample the pre-write value, so a write in the start cycle is
    // only seen by the following frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_src      <= DEF_SRC_MAC;
            r_dst      <= DEF_DST_MAC;
            r_sh_src   <= DEF_SRC_MAC;
            r_sh_dst   <= DEF_DST_MAC;
            r_readdata <= '0;
        end else begin
            if (avs_write) begin
                case (w_offset)
                    SOURCE_MAC_ADDR_1: r_src[47:32] <= avs_writedata[15:0];
                    SOURCE_MAC_ADDR_2: r_src[31:0]  <= avs_writedata;
                    DEST_MAC_ADDR_1:   r_dst[47:32] <= avs_writedata[15:0];
                    DEST_MAC_ADDR_2:   r_dst[31:0]  <= avs_writedata;
                    default: ;
                endcase
            end
            if (avs_read) begin
                r_readdata <= w_rd_mux;
            end
            if (i_start) begin
                r_sh_src <= r_src;
                r_sh_dst <= r_dst;
            end
        end
    end

endmodule

// File: rtl/aes_eth_tx_sequencer.sv
// Frames AES result blocks as Ethernet frames on a 32-bit Avalon-ST source:
// four header words followed by 1..BLOCKS_PER_FRAME blocks of four words.
//
// Handshakes: a word/block transfers on a cycle where valid && ready are
// both high at the rising edge. Once tx_valid is raised, tx_data/tx_sop/
// tx_eop stay constant until tx_ready accepts the word. aes_ready depends
// only on the FSM state, never on aes_valid.
module aes_eth_tx_sequencer
    import aes_top_pack::*;
#(
    parameter int          BLOCKS_PER_FRAME = 4,
    parameter logic [47:0] DEF_SRC_MAC      = 48'h0,
    parameter logic [47:0] DEF_DST_MAC      = 48'hFFFF_FFFF_FFFF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [ADDRESS_SIZE-1:0]      avs_address,
    input  logic                         avs_write,
    input  logic [REG_SIZE-1:0]          avs_writedata,
    input  logic                         avs_read,
    output logic [REG_SIZE-1:0]          avs_readdata,
    input  logic [AES_DATA_WIDTH-1:0]    aes_data,
    input  logic                         aes_valid,
    input  logic                         aes_last,
    output logic                         aes_ready,
    output logic [MAC_STREAM_WIDTH-1:0]  tx_data,
    output logic                         tx_valid,
    input  logic                         tx_ready,
    output logic                         tx_sop,
    output logic                         tx_eop,
    output logic [1:0]                   tx_empty,
    output logic [WORD_COUNTER_SIZE-1:0] frame_cnt,
    output logic [1:0]                   dbg_state
);

    localparam int                W_IDX      = $clog2(WORDS_PER_BLOCK);
    localparam logic [W_IDX-1:0]  LAST_PAY_W = W_IDX'(WORDS_PER_BLOCK - 1);
    localparam logic [W_IDX-1:0]  LAST_HDR_W = W_IDX'(HDR_WORDS - 1);
    localparam logic [5:0]        BPF_L      = 6'(BLOCKS_PER_FRAME);
    localparam logic              BPF_IS_ONE = (BLOCKS_PER_FRAME == 1);

    tx_state_e                    r_state;
    tx_state_e                    w_state_nxt;
    logic [W_IDX-1:0]             r_w;
    logic [AES_DATA_WIDTH-1:0]    r_hold;
    logic                         r_last;
    logic [5:0]                   r_blk_cnt;
    logic [5:0]                   w_blk_nxt;
    logic [WORD_COUNTER_SIZE-1:0] r_frame_cnt;
    logic                         w_ld_first;
    logic                         w_ld_next;
    logic                         w_w_inc;
    logic                         w_w_clr;
    logic                         w_frame_done;
    logic [47:0]                  w_sh_src;
    logic [47:0]                  w_sh_dst;

    assign w_blk_nxt = r_blk_cnt + 6'd1;
    assign frame_cnt = r_frame_cnt;
    assign dbg_state = r_state;
    assign tx_empty  = 2'b00;

    aes_mac_regs #(
        .DEF_SRC_MAC (DEF_SRC_MAC),
        .DEF_DST_MAC (DEF_DST_MAC)
    ) u_regs (
        .clk           (clk),
        .rst           (rst),
        .avs_address   (avs_address),
        .avs_write     (avs_write),
        .avs_writedata (avs_writedata),
        .avs_read      (avs_read),
        .avs_readdata  (avs_readdata),
        .i_frame_cnt   (r_frame_cnt),
        .i_start       (w_ld_first),
        .o_sh_src      (w_sh_src),
        .o_sh_dst      (w_sh_dst)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic and datapath strobes.
    always_comb begin
        w_state_nxt  = r_state;
        w_ld_first   = 1'b0;
        w_ld_next    = 1'b0;
        w_w_inc      = 1'b0;
        w_w_clr      = 1'b0;
        w_frame_done = 1'b0;
        case (r_state)
            IDLE: begin
                if (aes_valid) begin
                    w_state_nxt = HDR;
                    w_ld_first  = 1'b1;
                    w_w_clr     = 1'b1;
                end
            end
            HDR: begin
                if (tx_ready) begin
                    if (r_w == LAST_HDR_W) begin
                        w_state_nxt = PAYLOAD;
                        w_w_clr     = 1'b1;
                    end else begin
                        w_w_inc = 1'b1;
                    end
                end
            end
            PAYLOAD: begin
                if (tx_ready) begin
                    if (r_w == LAST_PAY_W) begin
                        w_w_clr = 1'b1;
                        if (r_last) begin
                            w_state_nxt  = IDLE;
                            w_frame_done = 1'b1;
                        end else begin
                            w_state_nxt = FETCH;
                        end
                    end else begin
                        w_w_inc = 1'b1;
                    end
                end
            end
            FETCH: begin
                if (aes_valid) begin
                    w_state_nxt = PAYLOAD;
                    w_ld_next   = 1'b1;
                    w_w_clr     = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Word index, block holding register, block count, last flag, frame count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_w         <= '0;
            r_hold      <= '0;
            r_last      <= 1'b0;
            r_blk_cnt   <= '0;
            r_frame_cnt <= '0;
        end else begin
            if (w_w_clr) begin
                r_w <= '0;
            end else if (w_w_inc) begin
                r_w <= r_w + W_IDX'(1);
            end
            if (w_ld_first) begin
                r_hold    <= aes_data;
                r_last    <= aes_last || BPF_IS_ONE;
                r_blk_cnt <= 6'd1;
            end else if (w_ld_next) begin
                r_hold    <= aes_data;
                r_last    <= aes_last || (w_blk_nxt == BPF_L);
                r_blk_cnt <= w_blk_nxt;
            end
            if (w_frame_done) begin
                r_frame_cnt <= r_frame_cnt + WORD_COUNTER_SIZE'(1);
            end
        end
    end

    // Stream outputs; everything is forced low while rst is asserted.
    always_comb begin
        aes_ready = 1'b0;
        tx_valid  = 1'b0;
        tx_sop    = 1'b0;
        tx_eop    = 1'b0;
        tx_data   = '0;
        if (!rst) begin
            case (r_state)
                IDLE, FETCH: aes_ready = 1'b1;
                HDR: begin
                    tx_valid = 1'b1;
                    tx_sop   = (r_w == '0);
                    case (r_w)
                        2'd0:    tx_data = {16'h0, w_sh_dst[47:32]};
                        2'd1:    tx_data = w_sh_dst[31:0];
                        2'd2:    tx_data = w_sh_src[47:16];
                        default: tx_data = {w_sh_src[15:0], ETH_TYPE};
                    endcase
                end
                PAYLOAD: begin
                    tx_valid = 1'b1;
                    tx_eop   = r_last && (r_w == LAST_PAY_W);
                    tx_data  = r_hold[AES_DATA_WIDTH-1-MAC_STREAM_WIDTH*int'(r_w) -: MAC_STREAM_WIDTH];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_eth_tx_sequencer.sv
// Bench for aes_eth_tx_sequencer: register vectors from a table, frame
// traffic checked against a queue of expected stream words.
module tb_aes_eth_tx_sequencer;
    import aes_top_pack::*;

    localparam int BPF = 4;

    logic                         clk = 1'b0;
    logic                         rst;
    logic [ADDRESS_SIZE-1:0]      avs_address;
    logic                         avs_write;
    logic [REG_SIZE-1:0]          avs_writedata;
    logic                         avs_read;
    logic [REG_SIZE-1:0]          avs_readdata;
    logic [AES_DATA_WIDTH-1:0]    aes_data;
    logic                         aes_valid;
    logic                         aes_last;
    logic                         aes_ready;
    logic [MAC_STREAM_WIDTH-1:0]  tx_data;
    logic                         tx_valid;
    logic                         tx_ready;
    logic                         tx_sop;
    logic                         tx_eop;
    logic [1:0]                   tx_empty;
    logic [WORD_COUNTER_SIZE-1:0] frame_cnt;
    logic [1:0]                   dbg_state;

    aes_eth_tx_sequencer #(
        .BLOCKS_PER_FRAME (BPF),
        .DEF_SRC_MAC      (48'h0),
        .DEF_DST_MAC      (48'hFFFF_FFFF_FFFF)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .avs_address   (avs_address),
        .avs_write     (avs_write),
        .avs_writedata (avs_writedata),
        .avs_read      (avs_read),
        .avs_readdata  (avs_readdata),
        .aes_data      (aes_data),
        .aes_valid     (aes_valid),
        .aes_last      (aes_last),
        .aes_ready     (aes_ready),
        .tx_data       (tx_data),
        .tx_valid      (tx_valid),
        .tx_ready      (tx_ready),
        .tx_sop        (tx_sop),
        .tx_eop        (tx_eop),
        .tx_empty      (tx_empty),
        .frame_cnt     (frame_cnt),
        .dbg_state     (dbg_state)
    );

    // Clock.
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Expected stream words: {sop, eop, data}.
    logic [33:0] exp_q[$];

    // Bench model of the register file and frame position.
    logic [47:0] m_src;
    logic [47:0] m_dst;
    bit          m_in_frame;
    int          m_blk;
    int          m_frames;

    bit          rdy_mode;
    bit          mon_en;
    bit          stall_prev;
    logic [33:0] stall_word;

    typedef struct {
        bit          wr;
        logic [31:0] off;
        logic [31:0] data;
        logic [31:0] exp;
    } reg_vec_t;

    reg_vec_t vt[18];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reg_write(input logic [31:0] off, input logic [31:0] data);
        avs_address   = PERIPHERAL_ADDR + off;
        avs_writedata = data;
        avs_write     = 1'b1;
        tick();
        avs_write     = 1'b0;
    endtask

    task automatic reg_read(input logic [31:0] off, output logic [31:0] data);
        avs_address = PERIPHERAL_ADDR + off;
        avs_read    = 1'b1;
        tick();
        avs_read    = 1'b0;
        data        = avs_readdata;
    endtask

    // Push the words a block is expected to produce.
    task automatic push_block(input logic [127:0] data, input bit last_in);
        bit is_last;
        if (!m_in_frame) begin
            exp_q.push_back({1'b1, 1'b0, 16'h0, m_dst[47:32]});
            exp_q.push_back({1'b0, 1'b0, m_dst[31:0]});
            exp_q.push_back({1'b0, 1'b0, m_src[47:16]});
            exp_q.push_back({1'b0, 1'b0, m_src[15:0], 16'h0800});
            m_blk      = 1;
            m_in_frame = 1'b1;
        end else begin
            m_blk++;
        end
        is_last = last_in || (m_blk == BPF);
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back({1'b0, (i == 3) && is_last, data[127-32*i -: 32]});
        end
        if (is_last) begin
            m_in_frame = 1'b0;
            m_frames++;
        end
    endtask

    task automatic send_block(input logic [127:0] data, input bit last_in);
        bit got = 1'b0;
        aes_data  = data;
        aes_last  = last_in;
        aes_valid = 1'b1;
        for (int c = 0; c < 400 && !got; c++) begin
            @(negedge clk);
            if (aes_ready) begin
                push_block(data, last_in);
                got = 1'b1;
            end
            tick();
        end
        aes_valid = 1'b0;
        aes_last  = 1'b0;
        chk("aes_accept", 64'(got), 64'd1);
    endtask

    task automatic drain(input int budget);
        for (int c = 0; c < budget && exp_q.size() != 0; c++) begin
            tick();
        end
        chk("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic wait_state(input tx_state_e st, input int budget);
        for (int c = 0; c < budget && dbg_state !== st; c++) begin
            tick();
        end
        chk("wait_state", 64'(dbg_state), 64'(st));
    endtask

    // Stream monitor: pops the scoreboard on each accepted word, checks that
    // stalled words are held, and that aes_ready stays low while busy.
    always @(negedge clk) begin
        if (!rst && mon_en) begin
            if (stall_prev) begin
                chk("stall_hold", 64'({tx_valid, tx_sop, tx_eop, tx_data}), 64'({1'b1, stall_word}));
            end
            if (tx_valid && tx_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_word", 64'({tx_sop, tx_eop, tx_data}), 64'h3_FFFF_FFFF_FFFF);
                end else begin
                    chk("tx_word", 64'({tx_sop, tx_eop, tx_data}), 64'(exp_q.pop_front()));
                end
                chk("tx_empty", 64'(tx_empty), 64'd0);
            end
            if (dbg_state == HDR || dbg_state == PAYLOAD) begin
                chk("aes_ready_busy", 64'(aes_ready), 64'd0);
            end
            stall_prev = tx_valid && !tx_ready;
            stall_word = {tx_sop, tx_eop, tx_data};
        end else begin
            stall_prev = 1'b0;
        end
    end

    // tx_ready driver for the backpressure phase.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode) begin
                tx_ready = 1'($urandom_range(0, 1));
            end
        end
    end

    // Global time limit.
    initial begin
        #2000000;
        $display("FAIL global_timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "time limit");
    end

    initial begin
        logic [31:0] rd;

        rst = 1'b1; avs_address = '0; avs_write = 1'b0; avs_writedata = '0;
        avs_read = 1'b0; aes_data = '0; aes_valid = 1'b0; aes_last = 1'b0;
        tx_ready = 1'b0; rdy_mode = 1'b0; mon_en = 1'b0; stall_prev = 1'b0;
        stall_word = '0;
        m_src = 48'h0; m_dst = 48'hFFFF_FFFF_FFFF; m_in_frame = 1'b0; m_blk = 0; m_frames = 0;

        vt[0]  = '{1'b0, 32'h08, 32'h0,         32'h0000_FFFF};
        vt[1]  = '{1'b0, 32'h0c, 32'h0,         32'hFFFF_FFFF};
        vt[2]  = '{1'b0, 32'h00, 32'h0,         32'h0};
        vt[3]  = '{1'b0, 32'h04, 32'h0,         32'h0};
        vt[4]  = '{1'b0, 32'h10, 32'h0,         32'h0};
        vt[5]  = '{1'b0, 32'h14, 32'h0,         32'h0};
        vt[6]  = '{1'b1, 32'h00, 32'hDEAD_0011, 32'h0};
        vt[7]  = '{1'b0, 32'h00, 32'h0,         32'h0000_0011};
        vt[8]  = '{1'b1, 32'h04, 32'h9999_9999, 32'h0};
        vt[9]  = '{1'b1, 32'h08, 32'h1234_A0B1, 32'h0};
        vt[10] = '{1'b0, 32'h08, 32'h0,         32'h0000_A0B1};
        vt[11] = '{1'b1, 32'h0c, 32'hC2D3_E4F5, 32'h0};
        vt[12] = '{1'b0, 32'h0c, 32'h0,         32'hC2D3_E4F5};
        vt[13] = '{1'b1, 32'h10, 32'h1234_5678, 32'h0};
        vt[14] = '{1'b0, 32'h10, 32'h0,         32'h0};
        vt[15] = '{1'b1, 32'h20, 32'h0000_ABCD, 32'h0};
        vt[16] = '{1'b0, 32'h20, 32'h0,         32'h0};
        vt[17] = '{1'b0, 32'h04, 32'h0,         32'h9999_9999};

        // Reset: outputs quiet while rst is high, defaults afterwards.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_aes_ready", 64'(aes_ready), 64'd0);
        chk("rst_tx_valid", 64'(tx_valid), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_aes_ready", 64'(aes_ready), 64'd1);
        chk("post_rst_tx", 64'({tx_valid, tx_sop, tx_eop, tx_empty, tx_data}), 64'd0);
        chk("post_rst_frame_cnt", 64'(frame_cnt), 64'd0);
        chk("post_rst_readdata", 64'(avs_readdata), 64'd0);
        chk("post_rst_state", 64'(dbg_state), 64'(IDLE));
        tick();
        mon_en = 1'b1;

        // Register vectors.
        for (int i = 0; i < 18; i++) begin
            if (vt[i].wr) begin
                reg_write(vt[i].off, vt[i].data);
            end else begin
                reg_read(vt[i].off, rd);
                chk($sformatf("reg_vec%0d", i), 64'(rd), 64'(vt[i].exp));
            end
        end

        // Simultaneous read and write of the same register returns the old value.
        avs_address   = PERIPHERAL_ADDR + 32'h04;
        avs_writedata = 32'h2233_4455;
        avs_write     = 1'b1;
        avs_read      = 1'b1;
        tick();
        avs_write = 1'b0;
        avs_read  = 1'b0;
        chk("rw_same_cycle", 64'(avs_readdata), 64'h9999_9999);
        tick();
        chk("readdata_hold", 64'(avs_readdata), 64'h9999_9999);
        reg_read(32'h04, rd);
        chk("rw_new_value", 64'(rd), 64'h2233_4455);
        m_src = 48'h0011_2233_4455;
        m_dst = 48'hA0B1_C2D3_E4F5;

        // Single frame with aes_last.
        tx_ready = 1'b1;
        send_block(128'h00010203_04050607_08090A0B_0C0D0E0F, 1'b1);
        drain(100);
        chk("frame_cnt_1", 64'(frame_cnt), 64'd1);

        // Full frame without aes_last, then a fifth block opening a new frame.
        for (int b = 0; b < 4; b++) begin
            send_block({$urandom(), $urandom(), $urandom(), $urandom()}, 1'b0);
        end
        send_block(128'hCAFEBABE_11111111_22222222_33333333, 1'b1);
        drain(200);
        chk("frame_cnt_full", 64'(frame_cnt), 64'(m_frames));

        // Backpressure.
        rdy_mode = 1'b1;
        send_block(128'h1111_2222_3333_4444_5555_6666_7777_8888, 1'b0);
        send_block(128'h9999_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF_0000, 1'b1);
        send_block(128'h0F0E_0D0C_0B0A_0908_0706_0504_0302_0100, 1'b1);
        for (int b = 0; b < 3; b++) begin
            send_block({$urandom(), $urandom(), $urandom(), $urandom()}, b == 2);
        end
        drain(1000);
        rdy_mode = 1'b0;
        tx_ready = 1'b1;
        tick();
        chk("frame_cnt_bp", 64'(frame_cnt), 64'(m_frames));

        // Destination write while a frame is in PAYLOAD.
        send_block(128'hAAAA0000_BBBB1111_CCCC2222_DDDD3333, 1'b1);
        wait_state(PAYLOAD, 50);
        reg_write(32'h08, 32'h0000_5566);
        reg_write(32'h0c, 32'h7788_99AA);
        m_dst = 48'h5566_7788_99AA;
        drain(100);
        send_block(128'h12345678_9ABCDEF0_0FEDCBA9_87654321, 1'b1);
        drain(100);
        reg_read(32'h10, rd);
        chk("frame_cnt_reg", 64'(rd), 64'(m_frames));

        // Reset while the third payload word is pending.
        send_block(128'h01010101_02020202_03030303_04040404, 1'b0);
        wait_state(PAYLOAD, 50);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_q.delete();
        m_in_frame = 1'b0;
        m_frames   = 0;
        m_src      = 48'h0;
        m_dst      = 48'hFFFF_FFFF_FFFF;
        @(negedge clk);
        chk("mid_rst_tx_valid", 64'(tx_valid), 64'd0);
        chk("mid_rst_state", 64'(dbg_state), 64'(IDLE));
        chk("mid_rst_frame_cnt", 64'(frame_cnt), 64'd0);
        tick();
        send_block(128'h55555555_66666666_77777777_88888888, 1'b1);
        drain(100);
        chk("post_rst_frame", 64'(frame_cnt), 64'd1);

        repeat (3) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/aes_eth_tx_sequencer.md
Name: aes_eth_tx_sequencer

Overview:
- Sequences the AES engine's 128-bit result blocks into Ethernet frames on the 32-bit Avalon-ST transmit interface of the TSE MAC.
- Each frame is a 128-bit MAC header (16-bit pad, destination MAC, source MAC, ETH_TYPE) followed by 1..BLOCKS_PER_FRAME AES blocks, serialized MSB-word first.
- Holds the source and destination MAC address registers, programmed over Avalon-MM at PERIPHERAL_ADDR.
- Sits between the AES core output and the TSE transmit FIFO.

Parameters:
- BLOCKS_PER_FRAME, 4, maximum AES blocks per frame, range 1..63.
- DEF_SRC_MAC, 48'h0, reset value of the source MAC register.
- DEF_DST_MAC, 48'hFFFF_FFFF_FFFF, reset value of the destination MAC register.

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- avs_address  in  ADDRESS_SIZE  byte address.
- avs_write  in  1  register write strobe.
- avs_writedata  in  REG_SIZE  write data.
- avs_read  in  1  register read strobe.
- avs_readdata  out  REG_SIZE  read data, valid one cycle after avs_read.
- aes_data  in  AES_DATA_WIDTH  AES result block.
- aes_valid  in  1  result block valid.
- aes_last  in  1  marks the block as the last of its frame.
- aes_ready  out  1  sequencer accepts the block.
- tx_data  out  MAC_STREAM_WIDTH  stream word to the TSE.
- tx_valid  out  1  stream word valid.
- tx_ready  in  1  TSE accepts the word.
- tx_sop  out  1  first word of frame.
- tx_eop  out  1  last word of frame.
- tx_empty  out  2  empty bytes in the current word; always 0.
- frame_cnt  out  WORD_COUNTER_SIZE  count of completed frames; wraps.

Behaviour:
- Register map; offset = avs_address − PERIPHERAL_ADDR:
  - SOURCE_MAC_ADDR_1 ('h0) = src[47:32] in bits [15:0]; bits [31:16] read 0.
  - SOURCE_MAC_ADDR_2 ('h4) = src[31:0].
  - DEST_MAC_ADDR_1 ('h8) = dst[47:32] in bits [15:0].
  - DEST_MAC_ADDR_2 ('hc) = dst[31:0].
  - 'h10 = frame_cnt, read-only.
  - Writes to unmapped or read-only offsets are ignored; reads of unmapped offsets return 0.
- Register read latency is 1 cycle; avs_readdata holds its value until the next read.
- States:
  - IDLE: aes_ready=1. On aes_valid, capture the block, the last flag (aes_last, or BLOCKS_PER_FRAME==1), and shadow copies of src/dst; set blk_cnt=1; go to HDR with w=0.
  - HDR: tx_valid=1; tx_sop=1 when w=0.
    - Words in order: w0 = {16'h0, dst[47:32]}; w1 = dst[31:0]; w2 = src[47:16]; w3 = {src[15:0], ETH_TYPE}.
    - w advances on tx_valid&&tx_ready; after w3 go to PAYLOAD with w=0.
  - PAYLOAD: tx_valid=1; tx_data = hold[127−32w −: 32].
    - On handshake at w=3: if the last flag is set, assert tx_eop on that word, increment frame_cnt, go to IDLE; otherwise go to FETCH.
  - FETCH: aes_ready=1, tx_valid=0. On aes_valid, capture the block and increment blk_cnt. Set last = aes_last || blk_cnt+1==BLOCKS_PER_FRAME. Go to PAYLOAD with w=0.
- aes_ready is 0 in HDR and PAYLOAD. A FETCH costs exactly one bubble cycle per block beyond the first.
- Word order and flags:
  - tx_data, tx_sop and tx_eop are held stable while tx_valid && !tx_ready.
  - The TSE must be built with the 16-bit shift (pad) option and auto-pads short frames.
  - No FCS is generated.
- Register writes take effect at the next frame start only, via the shadow copies. A write in the same cycle as frame start is not seen by that frame.
- A read and a write in the same cycle are both serviced. A read of a register written in the same cycle returns the old value.
- Reset values:
  - state = IDLE.
  - All tx_* outputs = 0; aes_ready = 0 during rst, 1 in the first cycle after.
  - Registers = DEF_*; frame_cnt = 0; avs_readdata = 0.
- Reset mid-frame abandons the frame with no eop; the TSE drops the truncated frame.
- frame_cnt wraps from 2^WORD_COUNTER_SIZE−1 to 0.

Decomposition:
- Add to aes_top_pack:
  - tx_state_e (IDLE, HDR, PAYLOAD, FETCH).
  - FRAME_CNT_ADDR = 'h10.
  - WORDS_PER_BLOCK = AES_DATA_WIDTH/MAC_STREAM_WIDTH.
  - HDR_WORDS = MAC_HEADER_WIDTH/MAC_STREAM_WIDTH.
- One sub-module, aes_mac_regs: the Avalon-MM register file plus shadow-on-start logic. The sequencer FSM lives in the top module.

Test Plan:
- Reset defaults: after rst, read 'h8 → 0x0000FFFF, 'hc → 0xFFFFFFFF, 'h0 → 0, 'h10 → 0.
- Single frame with last: write src 0x0011_2233_4455, dst 0xA0B1_C2D3_E4F5. Send one block 0x00010203_04050607_08090A0B_0C0D0E0F with aes_last=1, tx_ready=1. Expect:
  - 0x0000A0B1 (sop), 0xC2D3E4F5, 0x00112233, 0x44550800.
  - 0x00010203, 0x04050607, 0x08090A0B, 0x0C0D0E0F (eop).
  - frame_cnt = 1.
- Full frame without last: send 4 blocks, aes_last=0 throughout → one frame of 4 header + 16 payload words, eop on word 20. A fifth block starts a new frame with sop.
- Backpressure: toggle tx_ready pseudo-randomly → word sequence identical to the unstalled case, data held stable while stalled, aes_ready low outside IDLE and FETCH.
- Mid-frame register write: write dst during PAYLOAD → current frame keeps the old dst; the next frame's w0 and w1 carry the new dst.
- Reset during PAYLOAD word 2: tx_valid=0 the next cycle, state=IDLE, frame_cnt unchanged from its pre-reset value if nonzero is not required (it resets to 0); the next block produces a clean frame with sop.
